// File: rtl/sys_mem_arbiter.sv
// rtl/sys_mem_arbiter.sv - round-robin arbiter sharing one memory port among cache Sys channels
`timescale 1ns/1ps
module sys_mem_arbiter #(
  parameter int NUM_CH     = 2,
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255,
  localparam int GW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH-1:0]            ch_strobe,
  input  logic [NUM_CH-1:0]            ch_rw,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] ch_address,
  input  logic [NUM_CH*DATA_WIDTH-1:0] ch_wdata,
  output logic [DATA_WIDTH-1:0]        ch_rdata,
  output logic [NUM_CH-1:0]            ch_ready,
  output logic                         mem_enable,
  output logic                         mem_read,
  output logic                         mem_write,
  output logic [ADDR_WIDTH-1:0]        mem_address,
  output logic [DATA_WIDTH-1:0]        mem_in,
  input  logic [DATA_WIDTH-1:0]        mem_out,
  input  logic                         mem_ready,
  output logic [GW-1:0]                grant_id,
  output logic                         busy,
  output logic                         timeout_err
);

  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WW-1:0] WD_LAST = (TIMEOUT == 0) ? '0 : WW'(TIMEOUT - 1);
  localparam logic [GW-1:0] LAST_CH = GW'(NUM_CH - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                state_q, state_d;
  logic [GW-1:0]         rr_ptr;
  logic [WW-1:0]         wd_cnt;
  logic                  hold_rw;
  logic [ADDR_WIDTH-1:0] hold_addr;
  logic [DATA_WIDTH-1:0] hold_wdata;
  logic                  found;
  int                    sel_idx;
  logic                  wd_expire;

  assign wd_expire   = (TIMEOUT != 0) && (wd_cnt == WD_LAST);
  assign busy        = (state_q != IDLE);
  assign mem_address = hold_addr;
  assign mem_in      = hold_wdata;

  // Round-robin search: first requesting channel at or after rr_ptr, wrapping modulo NUM_CH.
  always_comb begin
    found   = 1'b0;
    sel_idx = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!found && ch_strobe[(int'(rr_ptr) + i) % NUM_CH]) begin
        found   = 1'b1;
        sel_idx = (int'(rr_ptr) + i) % NUM_CH;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic and state-decoded outputs; nothing here depends on inputs except transitions.
  always_comb begin
    state_d    = state_q;
    mem_enable = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ch_ready   = '0;
    case (state_q)
      IDLE: if (found) state_d = BUSY;
      BUSY: begin
        mem_enable = 1'b1;
        mem_read   = hold_rw;
        mem_write  = ~hold_rw;
        if (mem_ready || wd_expire) state_d = DONE;
      end
      DONE: begin
        ch_ready[grant_id] = 1'b1;
        state_d            = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Grant capture, watchdog, read-data return and round-robin pointer update.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rr_ptr      <= '0;
      wd_cnt      <= '0;
      grant_id    <= '0;
      ch_rdata    <= '0;
      timeout_err <= 1'b0;
      hold_rw     <= 1'b0;
      hold_addr   <= '0;
      hold_wdata  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (found) begin
            grant_id   <= sel_idx[GW-1:0];
            hold_rw    <= ch_rw[sel_idx];
            hold_addr  <= ch_address[sel_idx*ADDR_WIDTH +: ADDR_WIDTH];
            hold_wdata <= ch_wdata[sel_idx*DATA_WIDTH +: DATA_WIDTH];
            wd_cnt     <= '0;
          end
        end
        BUSY: begin
          wd_cnt <= wd_cnt + 1'b1;
          if (mem_ready) begin
            ch_rdata <= mem_out;
          end else if (wd_expire) begin
            ch_rdata    <= '0;
            timeout_err <= 1'b1;
          end
        end
        DONE: begin
          rr_ptr <= (grant_id == LAST_CH) ? '0 : grant_id + 1'b1;
          wd_cnt <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sys_mem_arbiter.sv
// tb/tb_sys_mem_arbiter.sv - directed self-checking bench for sys_mem_arbiter
`timescale 1ns/1ps
module tb_sys_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // two-channel instance, short watchdog
  logic        rst_a;
  logic [1:0]  a_strobe, a_rw;
  logic [23:0] a_addr;
  logic [63:0] a_wdata;
  logic [31:0] a_rdata;
  logic [1:0]  a_ready;
  logic        a_men, a_mrd, a_mwr;
  logic [11:0] a_maddr;
  logic [31:0] a_min, a_mout;
  logic        a_mrdy;
  logic        a_gid;
  logic        a_busy, a_terr;

  // three-channel instance
  logic        rst_b;
  logic [2:0]  b_strobe, b_rw;
  logic [35:0] b_addr;
  logic [95:0] b_wdata;
  logic [31:0] b_rdata;
  logic [2:0]  b_ready;
  logic        b_men, b_mrd, b_mwr;
  logic [11:0] b_maddr;
  logic [31:0] b_min, b_mout;
  logic        b_mrdy;
  logic [1:0]  b_gid;
  logic        b_busy, b_terr;

  sys_mem_arbiter #(.NUM_CH(2), .ADDR_WIDTH(12), .DATA_WIDTH(32), .TIMEOUT(4)) dut_a (
    .clk(clk), .rst(rst_a),
    .ch_strobe(a_strobe), .ch_rw(a_rw), .ch_address(a_addr), .ch_wdata(a_wdata),
    .ch_rdata(a_rdata), .ch_ready(a_ready),
    .mem_enable(a_men), .mem_read(a_mrd), .mem_write(a_mwr),
    .mem_address(a_maddr), .mem_in(a_min), .mem_out(a_mout), .mem_ready(a_mrdy),
    .grant_id(a_gid), .busy(a_busy), .timeout_err(a_terr)
  );

  sys_mem_arbiter #(.NUM_CH(3), .ADDR_WIDTH(12), .DATA_WIDTH(32), .TIMEOUT(255)) dut_b (
    .clk(clk), .rst(rst_b),
    .ch_strobe(b_strobe), .ch_rw(b_rw), .ch_address(b_addr), .ch_wdata(b_wdata),
    .ch_rdata(b_rdata), .ch_ready(b_ready),
    .mem_enable(b_men), .mem_read(b_mrd), .mem_write(b_mwr),
    .mem_address(b_maddr), .mem_in(b_min), .mem_out(b_mout), .mem_ready(b_mrdy),
    .grant_id(b_gid), .busy(b_busy), .timeout_err(b_terr)
  );

  task automatic reset_a();
    @(negedge clk);
    rst_a = 1'b0; a_strobe = '0; a_mrdy = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_a = 1'b1;
  endtask

  task automatic reset_b();
    @(negedge clk);
    rst_b = 1'b0; b_strobe = '0; b_mrdy = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_b = 1'b1;
  endtask

  task automatic test_reset();
    reset_a();
    checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", a_busy); end
    checks++; if (a_men !== 1'b0) begin failures++; $display("FAIL reset_men got=%b exp=0", a_men); end
    checks++; if (a_ready !== 2'b00) begin failures++; $display("FAIL reset_ready got=%b exp=00", a_ready); end
    checks++; if (a_gid !== 1'b0) begin failures++; $display("FAIL reset_gid got=%b exp=0", a_gid); end
    checks++; if (a_terr !== 1'b0) begin failures++; $display("FAIL reset_terr got=%b exp=0", a_terr); end
    checks++; if (a_rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", a_rdata); end
  endtask

  task automatic test_single_read();
    reset_a();
    a_addr = {12'h5C3, 12'h111}; a_rw = 2'b11; a_mout = 32'h0; a_strobe = 2'b10;
    @(negedge clk);
    checks++; if ({a_men, a_mrd, a_mwr} !== 3'b110) begin failures++; $display("FAIL rd_ctl1 got=%b exp=110", {a_men, a_mrd, a_mwr}); end
    checks++; if (a_maddr !== 12'h5C3) begin failures++; $display("FAIL rd_addr1 got=%h exp=5c3", a_maddr); end
    checks++; if (a_gid !== 1'b1) begin failures++; $display("FAIL rd_gid1 got=%b exp=1", a_gid); end
    @(negedge clk);
    checks++; if ({a_men, a_mrd, a_maddr} !== {2'b11, 12'h5C3}) begin failures++; $display("FAIL rd_cyc2 got=%b%b_%h exp=11_5c3", a_men, a_mrd, a_maddr); end
    checks++; if (a_ready !== 2'b00) begin failures++; $display("FAIL rd_early_ready got=%b exp=00", a_ready); end
    a_mrdy = 1'b1; a_mout = 32'hDEADBEEF;
    @(negedge clk);
    checks++; if (a_ready !== 2'b10) begin failures++; $display("FAIL rd_ready got=%b exp=10", a_ready); end
    checks++; if (a_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL rd_data got=%h exp=deadbeef", a_rdata); end
    checks++; if (a_men !== 1'b0) begin failures++; $display("FAIL rd_done_men got=%b exp=0", a_men); end
    a_strobe = 2'b00; a_mrdy = 1'b0;
    @(negedge clk);
    checks++; if ({a_ready, a_busy} !== 3'b000) begin failures++; $display("FAIL rd_after got=%b exp=000", {a_ready, a_busy}); end
  endtask

  task automatic test_back_to_back();
    int t0 = -1;
    int t1 = -1;
    reset_a();
    a_addr = {12'h222, 12'h111}; a_rw = 2'b11; a_mout = 32'h1; a_mrdy = 1'b1; a_strobe = 2'b11;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (a_ready == 2'b01 && t0 < 0) begin t0 = n; a_strobe[0] = 1'b0; end
      if (a_ready == 2'b10 && t1 < 0) begin t1 = n; a_strobe[1] = 1'b0; end
      if (t0 >= 0 && t1 >= 0) break;
    end
    a_strobe = 2'b00; a_mrdy = 1'b0;
    checks++; if (t0 !== 2) begin failures++; $display("FAIL b2b_first got=%0d exp=2", t0); end
    checks++; if (t1 - t0 !== 3) begin failures++; $display("FAIL b2b_gap got=%0d exp=3", t1 - t0); end
    @(negedge clk);
  endtask

  task automatic test_round_robin3();
    int exp_order[6] = '{0, 1, 2, 0, 1, 2};
    int got[6];
    int when[6];
    int k = 0;
    int idx;
    reset_b();
    b_addr = {12'h333, 12'h222, 12'h111}; b_rw = 3'b111; b_mout = 32'h5; b_mrdy = 1'b1; b_strobe = 3'b111;
    for (int n = 1; n <= 40 && k < 6; n++) begin
      @(negedge clk);
      if (b_ready != 3'b000) begin
        case (b_ready)
          3'b001:  idx = 0;
          3'b010:  idx = 1;
          3'b100:  idx = 2;
          default: idx = 7;
        endcase
        got[k] = idx; when[k] = n; k++;
      end
    end
    b_strobe = 3'b000; b_mrdy = 1'b0;
    checks++; if (k !== 6) begin failures++; $display("FAIL rr3_count got=%0d exp=6", k); end
    for (int i = 0; i < k; i++) begin
      checks++; if (got[i] !== exp_order[i]) begin failures++; $display("FAIL rr3_order[%0d] got=%0d exp=%0d", i, got[i], exp_order[i]); end
    end
    for (int i = 1; i < k; i++) begin
      checks++; if (when[i] - when[i-1] !== 3) begin failures++; $display("FAIL rr3_gap[%0d] got=%0d exp=3", i, when[i] - when[i-1]); end
    end
    @(negedge clk);
  endtask

  task automatic test_write();
    reset_a();
    a_addr = {12'h777, 12'h0A4}; a_wdata = {32'h0, 32'h12345678}; a_rw = 2'b00; a_strobe = 2'b01;
    @(negedge clk);
    checks++; if ({a_men, a_mrd, a_mwr} !== 3'b101) begin failures++; $display("FAIL wr_ctl got=%b exp=101", {a_men, a_mrd, a_mwr}); end
    checks++; if (a_min !== 32'h12345678) begin failures++; $display("FAIL wr_min got=%h exp=12345678", a_min); end
    checks++; if (a_maddr !== 12'h0A4) begin failures++; $display("FAIL wr_addr got=%h exp=0a4", a_maddr); end
    a_wdata[31:0] = 32'hFFFF0000; a_addr[11:0] = 12'h3FF;
    @(negedge clk);
    checks++; if (a_min !== 32'h12345678) begin failures++; $display("FAIL wr_min_held got=%h exp=12345678", a_min); end
    checks++; if (a_maddr !== 12'h0A4) begin failures++; $display("FAIL wr_addr_held got=%h exp=0a4", a_maddr); end
    a_mrdy = 1'b1; a_mout = 32'hCAFEF00D;
    @(negedge clk);
    checks++; if (a_ready !== 2'b01) begin failures++; $display("FAIL wr_ready got=%b exp=01", a_ready); end
    checks++; if (a_rdata !== 32'hCAFEF00D) begin failures++; $display("FAIL wr_rdata got=%h exp=cafef00d", a_rdata); end
    a_strobe = 2'b00; a_mrdy = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int busy_cycles = 0;
    bit done = 0;
    reset_a();
    a_rw = 2'b11; a_addr = {12'h0C0, 12'h0B0}; a_mout = 32'h55AA55AA; a_mrdy = 1'b1; a_strobe = 2'b01;
    for (int n = 0; n < 10 && !done; n++) begin
      @(negedge clk);
      if (a_ready != 2'b00) done = 1;
    end
    checks++; if (a_rdata !== 32'h55AA55AA) begin failures++; $display("FAIL to_pre_rdata got=%h exp=55aa55aa", a_rdata); end
    a_strobe = 2'b00; a_mrdy = 1'b0;
    @(negedge clk);
    a_mout = 32'h77777777; a_strobe = 2'b10;
    done = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (a_ready != 2'b00) begin done = 1; break; end
      if (a_men) busy_cycles++;
    end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL to_no_done got=%b exp=1", done); end
    checks++; if (busy_cycles !== 4) begin failures++; $display("FAIL to_busy_cycles got=%0d exp=4", busy_cycles); end
    checks++; if (a_ready !== 2'b10) begin failures++; $display("FAIL to_ready got=%b exp=10", a_ready); end
    checks++; if (a_rdata !== 32'h0) begin failures++; $display("FAIL to_rdata got=%h exp=0", a_rdata); end
    checks++; if (a_terr !== 1'b1) begin failures++; $display("FAIL to_err got=%b exp=1", a_terr); end
    a_strobe = 2'b00;
    repeat (3) @(negedge clk);
    checks++; if ({a_terr, a_busy} !== 2'b10) begin failures++; $display("FAIL to_sticky got=%b exp=10", {a_terr, a_busy}); end
    reset_a();
    checks++; if (a_terr !== 1'b0) begin failures++; $display("FAIL to_clear got=%b exp=0", a_terr); end
  endtask

  task automatic test_reset_busy();
    reset_a();
    a_addr = {12'h155, 12'h0AA}; a_rw = 2'b11; a_mrdy = 1'b0; a_strobe = 2'b10;
    @(negedge clk);
    checks++; if ({a_busy, a_gid} !== 2'b11) begin failures++; $display("FAIL rb_pre got=%b exp=11", {a_busy, a_gid}); end
    rst_a = 1'b0; a_strobe = 2'b11;
    @(negedge clk);
    checks++; if ({a_busy, a_men, a_ready, a_gid} !== 5'b00000) begin failures++; $display("FAIL rb_reset got=%b exp=00000", {a_busy, a_men, a_ready, a_gid}); end
    rst_a = 1'b1;
    @(negedge clk);
    checks++; if ({a_busy, a_gid, a_ready} !== 4'b1000) begin failures++; $display("FAIL rb_regrant got=%b exp=1000", {a_busy, a_gid, a_ready}); end
    checks++; if (a_maddr !== 12'h0AA) begin failures++; $display("FAIL rb_addr got=%h exp=0aa", a_maddr); end
    a_mrdy = 1'b1;
    @(negedge clk);
    checks++; if (a_ready !== 2'b01) begin failures++; $display("FAIL rb_ready got=%b exp=01", a_ready); end
    a_strobe = 2'b00; a_mrdy = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst_a = 1'b0; a_strobe = '0; a_rw = '0; a_addr = '0; a_wdata = '0; a_mout = '0; a_mrdy = 1'b0;
    rst_b = 1'b0; b_strobe = '0; b_rw = '0; b_addr = '0; b_wdata = '0; b_mout = '0; b_mrdy = 1'b0;
    test_reset();
    test_single_read();
    test_back_to_back();
    test_round_robin3();
    test_write();
    test_timeout();
    test_reset_busy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
